// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM sharing one req/ready memory port.
// Owns IR/MDR, drives per-state datapath strobes, traps on illegal opcodes and memory stalls.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    input  logic             alu_zero,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic [31:0]      ir,
    output logic [31:0]      mdr,
    output logic             reg_alu_mux,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             data_reg_mux,
    output logic             pc_write,
    output logic             pc_src,
    output logic             trap,
    output logic             trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    // state   | meaning
    // IDLE    | waiting for run
    // FETCH   | instruction read at PC
    // DECODE  | opcode legality check
    // EXECUTE | ALU op; branches retire here
    // MEM     | load/store access at ALU address; stores retire here
    // WB      | register write-back, PC+4, retire
    // TRAP    | halted until reset
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic [31:0]       r_ir;
    logic [31:0]       r_mdr;
    logic [CNT_W-1:0]  r_instret;
    logic              r_trap;
    logic              r_trap_cause;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_op;
    logic       w_is_imm;
    logic       w_is_branch;
    logic       w_legal;
    logic       w_retire;
    logic       w_set_trap;
    logic       w_trap_cause;

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_is_load   = (w_opcode == OPC_LOAD);
    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_is_op     = (w_opcode == OPC_OP);
    assign w_is_imm    = (w_opcode == OPC_IMM);
    assign w_is_branch = (w_opcode == OPC_BRANCH);
    assign w_legal     = w_is_load || w_is_store || w_is_op || w_is_imm ||
                         (w_is_branch && (w_funct3 == 3'b000 || w_funct3 == 3'b001));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        reg_alu_mux  = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        data_reg_mux = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        w_retire     = 1'b0;
        w_set_trap   = 1'b0;
        w_trap_cause = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                // a ready arriving in the limit cycle still wins over the timeout
                if (mem_ready) begin
                    w_next = S_DECODE;
                end else if (r_wait == WAIT_LIMIT) begin
                    w_next       = S_TRAP;
                    w_set_trap   = 1'b1;
                    w_trap_cause = 1'b1;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_next     = S_TRAP;
                    w_set_trap = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (w_is_op) begin
                    alu_op = 2'b10;
                    w_next = S_WB;
                end else if (w_is_imm) begin
                    alu_op      = 2'b10;
                    reg_alu_mux = 1'b1;
                    w_next      = S_WB;
                end else if (w_is_load || w_is_store) begin
                    reg_alu_mux = 1'b1;
                    w_next      = S_MEM;
                end else if (w_is_branch) begin
                    alu_op   = 2'b01;
                    pc_write = 1'b1;
                    pc_src   = w_funct3[0] ? !alu_zero : alu_zero;
                    w_retire = 1'b1;
                    w_next   = run ? S_FETCH : S_IDLE;
                end else begin
                    w_next     = S_TRAP;
                    w_set_trap = 1'b1;
                end
            end
            S_MEM: begin
                mem_req     = 1'b1;
                addr_sel    = 1'b1;
                mem_we      = w_is_store;
                reg_alu_mux = 1'b1;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_write = 1'b1;
                        w_retire = 1'b1;
                        w_next   = run ? S_FETCH : S_IDLE;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (r_wait == WAIT_LIMIT) begin
                    w_next       = S_TRAP;
                    w_set_trap   = 1'b1;
                    w_trap_cause = 1'b1;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                data_reg_mux = w_is_load;
                pc_write     = 1'b1;
                w_retire     = 1'b1;
                w_next       = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                w_next = S_TRAP;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait       <= '0;
            r_ir         <= '0;
            r_mdr        <= '0;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (mem_req && !mem_ready && r_wait != WAIT_LIMIT) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
            if (r_state == S_FETCH && mem_ready) r_ir <= mem_rdata;
            if (r_state == S_MEM && mem_ready && w_is_load) r_mdr <= mem_rdata;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
            if (w_set_trap) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause;
            end
        end
    end

    assign ir         = r_ir;
    assign mdr        = r_mdr;
    assign instret    = r_instret;
    assign trap       = r_trap;
    assign trap_cause = r_trap_cause;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction phase model derived from the ISA-level rules,
// checked every cycle, plus literal latency / register expectations.
module tb_multicycle_sequencer;
    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [31:0] W_ADD = 32'h002081B3;
    localparam logic [31:0] W_LW  = 32'h0000A183;
    localparam logic [31:0] W_SW  = 32'h0020A023;
    localparam logic [31:0] W_BEQ = 32'h00208063;
    localparam logic [31:0] W_BNE = 32'h00209063;
    localparam logic [31:0] W_ILL = 32'h0000007F;

    logic clk = 1'b0;
    logic reset, run, mem_ready, alu_zero;
    logic [31:0] mem_rdata;
    logic mem_req, mem_we, addr_sel, reg_alu_mux, reg_write, data_reg_mux, pc_write, pc_src;
    logic trap, trap_cause;
    logic [1:0] alu_op;
    logic [2:0] state;
    logic [31:0] ir, mdr;
    logic [CNT_W-1:0] instret;

    multicycle_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir(ir), .mdr(mdr), .reg_alu_mux(reg_alu_mux), .alu_op(alu_op), .reg_write(reg_write),
        .data_reg_mux(data_reg_mux), .pc_write(pc_write), .pc_src(pc_src), .trap(trap),
        .trap_cause(trap_cause), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic mem_req, mem_we, addr_sel, reg_alu_mux;
        logic [1:0] alu_op;
        logic reg_write, data_reg_mux, pc_write, pc_src, trap, trap_cause;
        logic [2:0] state;
        logic [31:0] ir, mdr;
        logic [CNT_W-1:0] instret;
    } obs_t;

    obs_t got;
    assign got = {mem_req, mem_we, addr_sel, reg_alu_mux, alu_op, reg_write, data_reg_mux,
                  pc_write, pc_src, trap, trap_cause, state, ir, mdr, instret};

    logic [31:0] m_ir, m_mdr;
    logic [CNT_W-1:0] m_instret;
    logic m_trap, m_cause;
    bit m_at_fetch, run_low;
    int lat, checks, errors;

    function automatic bit is_legal(input logic [31:0] w);
        case (w[6:0])
            OPC_LOAD, OPC_IMM, OPC_OP, OPC_STORE: return 1'b1;
            OPC_BR: return (w[14:12] == 3'b000) || (w[14:12] == 3'b001);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic rnd_run();
        return run_low ? 1'b0 : rbit();
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.state = st;
        e.ir = m_ir;
        e.mdr = m_mdr;
        e.instret = m_instret;
        e.trap = m_trap;
        e.trap_cause = m_cause;
        return e;
    endfunction

    task automatic cycle(input obs_t e, input string tag);
        @(negedge clk);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, e);
        end
        @(posedge clk);
        #1;
        lat++;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        m_ir = '0; m_mdr = '0; m_instret = '0; m_trap = 1'b0; m_cause = 1'b0;
        m_at_fetch = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_async got=%h exp=0", got);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_idle(input logic r);
        run = r; mem_ready = rbit(); mem_rdata = $urandom; alu_zero = rbit();
        cycle(blank(3'd0), "idle");
        m_at_fetch = r;
    endtask

    // up to MEM_TIMEOUT wait cycles are tolerated; one more stalled cycle traps
    task automatic do_fetch(input logic [31:0] word, input int wait_n, output bit ok);
        obs_t e;
        ok = 1'b0;
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            run = rnd_run(); alu_zero = rbit();
            mem_ready = (k == wait_n);
            mem_rdata = mem_ready ? word : $urandom;
            e = blank(3'd1);
            e.mem_req = 1'b1;
            cycle(e, "fetch");
            if (k == wait_n) begin
                m_ir = word;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin m_trap = 1'b1; m_cause = 1'b1; end
    endtask

    task automatic do_decode(output bit legal);
        run = rnd_run(); mem_ready = rbit(); mem_rdata = $urandom; alu_zero = rbit();
        cycle(blank(3'd2), "decode");
        legal = is_legal(m_ir);
        if (!legal) begin m_trap = 1'b1; m_cause = 1'b0; end
    endtask

    task automatic do_execute(input logic zero, input logic run_end);
        obs_t e;
        logic [6:0] opc;
        opc = m_ir[6:0];
        e = blank(3'd3);
        mem_ready = rbit(); mem_rdata = $urandom; alu_zero = zero; run = rnd_run();
        if (opc == OPC_OP) begin
            e.alu_op = 2'b10;
        end else if (opc == OPC_IMM) begin
            e.alu_op = 2'b10; e.reg_alu_mux = 1'b1;
        end else if (opc == OPC_LOAD || opc == OPC_STORE) begin
            e.reg_alu_mux = 1'b1;
        end else begin
            e.alu_op = 2'b01; e.pc_write = 1'b1;
            e.pc_src = (m_ir[14:12] == 3'b000) ? zero : !zero;
            run = run_end;
        end
        cycle(e, "execute");
        if (opc == OPC_BR) begin
            m_instret = m_instret + 1;
            m_at_fetch = run_end;
        end
    endtask

    task automatic do_mem(input int wait_n, input logic [31:0] data, input logic run_end,
                          input int stop_after, output bit ok);
        obs_t e;
        bit st;
        st = (m_ir[6:0] == OPC_STORE);
        ok = 1'b0;
        for (int k = 0; k <= MEM_TIMEOUT; k++) begin
            if (k == stop_after) return;
            mem_ready = (k == wait_n);
            mem_rdata = mem_ready ? data : $urandom;
            alu_zero = rbit();
            run = (mem_ready && st) ? run_end : rnd_run();
            e = blank(3'd4);
            e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st; e.reg_alu_mux = 1'b1;
            if (mem_ready && st) e.pc_write = 1'b1;
            cycle(e, "mem");
            if (k == wait_n) begin
                ok = 1'b1;
                if (st) begin
                    m_instret = m_instret + 1;
                    m_at_fetch = run_end;
                end else begin
                    m_mdr = data;
                end
                break;
            end
        end
        if (!ok) begin m_trap = 1'b1; m_cause = 1'b1; end
    endtask

    task automatic do_wb(input logic run_end);
        obs_t e;
        e = blank(3'd5);
        e.reg_write = 1'b1;
        e.data_reg_mux = (m_ir[6:0] == OPC_LOAD);
        e.pc_write = 1'b1;
        run = run_end; mem_ready = rbit(); mem_rdata = $urandom; alu_zero = rbit();
        cycle(e, "wb");
        m_instret = m_instret + 1;
        m_at_fetch = run_end;
    endtask

    task automatic do_trap(input int n);
        for (int k = 0; k < n; k++) begin
            run = rbit(); mem_ready = rbit(); mem_rdata = $urandom; alu_zero = rbit();
            cycle(blank(3'd6), "trap_hold");
        end
    endtask

    task automatic exec_instr(input logic [31:0] word, input int fwait, input int mwait,
                              input logic [31:0] data, input logic zero, input logic run_end,
                              output bit trapped);
        bit ok, legal;
        logic [6:0] opc;
        trapped = 1'b0;
        if (!m_at_fetch) do_idle(1'b1);
        lat = 0;
        do_fetch(word, fwait, ok);
        if (!ok) begin trapped = 1'b1; return; end
        do_decode(legal);
        if (!legal) begin trapped = 1'b1; return; end
        opc = word[6:0];
        do_execute(zero, run_end);
        if (opc == OPC_BR) return;
        if (opc == OPC_LOAD || opc == OPC_STORE) begin
            do_mem(mwait, data, run_end, -1, ok);
            if (!ok) begin trapped = 1'b1; return; end
            if (opc == OPC_STORE) return;
        end
        do_wb(run_end);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit tr, ok, legal;
        int sel, fw, mw;
        logic [31:0] w;
        checks = 0; errors = 0; lat = 0; run_low = 1'b0;
        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = '0; alu_zero = 1'b0;
        model_clear();
        #3;
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_initial got=%h exp=0", got);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_idle(1'b0);
        do_idle(1'b0);

        exec_instr(W_ADD, 0, 0, 32'h0, 1'b0, 1'b1, tr);
        check_val("add_latency", 32'(lat), 32'd4);
        check_val("add_instret", instret, 32'd1);

        exec_instr(W_LW, 0, 0, 32'h12345678, 1'b0, 1'b1, tr);
        check_val("lw_latency", 32'(lat), 32'd5);
        exec_instr(W_LW, 0, 3, 32'hCAFEF00D, 1'b0, 1'b1, tr);
        check_val("lw_wait3_latency", 32'(lat), 32'd8);
        check_val("lw_mdr", mdr, 32'hCAFEF00D);
        exec_instr(W_SW, 0, 0, 32'h0, 1'b0, 1'b1, tr);
        check_val("sw_latency", 32'(lat), 32'd4);
        exec_instr(W_BEQ, 0, 0, 32'h0, 1'b1, 1'b1, tr);
        check_val("beq_latency", 32'(lat), 32'd3);
        exec_instr(W_BEQ, 0, 0, 32'h0, 1'b0, 1'b1, tr);
        exec_instr(W_BNE, 0, 0, 32'h0, 1'b0, 1'b1, tr);
        exec_instr(W_BNE, 0, 0, 32'h0, 1'b1, 1'b1, tr);
        check_val("instret_after_8", instret, 32'd8);
        exec_instr(W_ADD, 16, 0, 32'h0, 1'b0, 1'b1, tr);
        check_val("fetch_wait16_latency", 32'(lat), 32'd20);
        check_val("fetch_wait16_no_trap", {31'b0, trap}, 32'd0);

        exec_instr(W_ILL, 0, 0, 32'h0, 1'b0, 1'b1, tr);
        do_trap(20);
        check_val("illegal_trap", {31'b0, trap}, 32'd1);
        check_val("illegal_cause", {31'b0, trap_cause}, 32'd0);
        do_reset();

        exec_instr(W_ADD, 17, 0, 32'h0, 1'b0, 1'b1, tr);
        do_trap(4);
        check_val("fetch_timeout_cause", {31'b0, trap_cause}, 32'd1);
        do_reset();
        exec_instr(W_LW, 0, 20, 32'h0, 1'b0, 1'b1, tr);
        do_trap(3);
        check_val("mem_timeout_cause", {31'b0, trap_cause}, 32'd1);
        do_reset();
        exec_instr(W_SW, 0, 16, 32'h0, 1'b0, 1'b1, tr);
        check_val("sw_wait16_instret", instret, 32'd1);

        do_reset();
        do_idle(1'b1);
        do_fetch(W_LW, 0, ok);
        do_decode(legal);
        do_execute(1'b0, 1'b1);
        do_mem(10, 32'h0, 1'b1, 3, ok);
        do_reset();

        run_low = 1'b1;
        exec_instr(W_LW, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0, tr);
        run_low = 1'b0;
        do_idle(1'b0);
        do_idle(1'b0);
        check_val("run_drop_instret", instret, 32'd1);
        check_val("run_drop_mdr", mdr, 32'hDEADBEEF);

        for (int n = 0; n < 200; n++) begin
            sel = $urandom_range(0, 99);
            fw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 2);
            w = $urandom;
            if (sel < 3) begin
                if (is_legal(w)) w[6:0] = 7'b1111111;
            end else begin
                case ($urandom_range(0, 5))
                    0: w[6:0] = OPC_LOAD;
                    1: w[6:0] = OPC_STORE;
                    2: w[6:0] = OPC_OP;
                    3: w[6:0] = OPC_IMM;
                    default: begin
                        w[6:0] = OPC_BR;
                        w[14:12] = {2'b00, rbit()};
                    end
                endcase
                if (sel < 5) fw = $urandom_range(17, 20);
                else if (sel < 8) mw = $urandom_range(17, 20);
            end
            exec_instr(w, fw, mw, $urandom, rbit(), ($urandom_range(0, 3) != 0), tr);
            if (tr) begin
                do_trap(3);
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
